// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// State, read-owner tag and beat size.
package dmem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE,
    CPU_RD,
    ACC_BURST
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_ACC
  } rd_owner_t;

  localparam int BEAT_BYTES = 4;
endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, accelerator and memory bus bundle.
// slave = arbiter view, master = environment view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 5
) ();
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W/8-1:0] cpu_wmask;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_valid;
  logic              cpu_stall;

  logic              acc_req;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [LEN_W-1:0]  acc_len;
  logic              acc_gnt;
  logic              acc_beat;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_rvalid;
  logic [DATA_W-1:0] acc_rdata;
  logic              acc_done;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr,
    input  cpu_wdata, cpu_wmask,
    output cpu_rdata, cpu_valid, cpu_stall,
    input  acc_req, acc_we, acc_addr,
    input  acc_len, acc_wdata,
    output acc_gnt, acc_beat, acc_rvalid,
    output acc_rdata, acc_done,
    output mem_en, mem_we, mem_addr,
    output mem_wdata, mem_wmask,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr,
    output cpu_wdata, cpu_wmask,
    input  cpu_rdata, cpu_valid, cpu_stall,
    output acc_req, acc_we, acc_addr,
    output acc_len, acc_wdata,
    input  acc_gnt, acc_beat, acc_rvalid,
    input  acc_rdata, acc_done,
    input  mem_en, mem_we, mem_addr,
    input  mem_wdata, mem_wmask,
    output mem_rdata
  );
endinterface

// File: rtl/burst_addr_gen.sv
// Accelerator burst address generator.
// Beat 0 goes out on grant; this tracks beats 1..len-1.
module burst_addr_gen
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [LEN_W-1:0]  idx_o,
  output logic              last_o
);
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;

  // Latch the burst on grant, step the index per beat.
  always_comb begin
    base_d = base_q;
    len_d  = len_q;
    idx_d  = idx_q;
    if (load_i) begin
      base_d = base_i;
      len_d  = len_i;
      idx_d  = LEN_W'(1);
    end else if (adv_i) begin
      idx_d = idx_q + LEN_W'(1);
    end
  end

  // Burst registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else begin
      base_q <= base_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
    end
  end

  assign addr_o = base_q +
    ADDR_W'(idx_q) * ADDR_W'(BEAT_BYTES);
  assign idx_o  = idx_q;
  assign last_o = (idx_q == len_q - LEN_W'(1));
endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU load/store vs GEMM bursts.
// CPU first, unless the accelerator has starved.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_BURST  = 16,
  parameter int STARVE_LIM = 8
) (
  input logic       clk,
  input logic       reset,
  dmem_arbiter_if.slave bus
);
  localparam int LEN_W  = $clog2(MAX_BURST) + 1;
  localparam int CNT_W  = $clog2(STARVE_LIM + 1);
  localparam int MASK_W = DATA_W / 8;

  arb_state_t        state_q, state_d;
  rd_owner_t         own_q, own_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              done_q, done_d;
  logic              we_q;

  logic [ADDR_W-1:0] gen_addr;
  logic [LEN_W-1:0]  beat_idx;
  logic              last_beat;
  logic [LEN_W-1:0]  len_c;
  logic starved, idle, cpu_win, acc_win;
  logic beat0, burst_beat, burst_end, cpu_rd;

  assign starved    = (starve_q >= CNT_W'(STARVE_LIM));
  assign idle       = !reset && (state_q == IDLE);
  assign cpu_win    = idle && bus.cpu_req &&
                      !(bus.acc_req && starved);
  assign acc_win    = idle && bus.acc_req && !cpu_win;
  assign len_c      = (bus.acc_len > LEN_W'(MAX_BURST)) ?
                      LEN_W'(MAX_BURST) : bus.acc_len;
  assign beat0      = acc_win && (len_c != '0);
  assign burst_beat = !reset && (state_q == ACC_BURST);
  assign burst_end  = (acc_win && len_c <= LEN_W'(1)) ||
                      (burst_beat && last_beat);
  assign cpu_rd     = !reset && (state_q == CPU_RD);

  burst_addr_gen #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_gen (
    .clk   (clk),
    .reset (reset),
    .load_i(acc_win),
    .adv_i (burst_beat),
    .base_i(bus.acc_addr),
    .len_i (len_c),
    .addr_o(gen_addr),
    .idx_o (beat_idx),
    .last_o(last_beat)
  );

  // Next state, owner tag, done pulse and starve count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_win && !bus.cpu_we)
          state_d = CPU_RD;
        else if (acc_win && len_c > LEN_W'(1))
          state_d = ACC_BURST;
      end
      CPU_RD:    state_d = IDLE;
      ACC_BURST: if (last_beat) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    own_d = OWN_NONE;
    if (cpu_win && !bus.cpu_we)
      own_d = OWN_CPU;
    else if (beat0 && !bus.acc_we)
      own_d = OWN_ACC;
    else if (burst_beat && !we_q)
      own_d = OWN_ACC;
    done_d   = burst_end;
    starve_d = starve_q;
    if (acc_win)
      starve_d = '0;
    else if (bus.acc_req && !starved)
      starve_d = starve_q + CNT_W'(1);
  end

  // FSM and response-steering registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      own_q    <= OWN_NONE;
      starve_q <= '0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      starve_q <= starve_d;
      done_q   <= done_d;
      if (acc_win) we_q <= bus.acc_we;
    end
  end

  // Memory port mux.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    unique case (1'b1)
      cpu_win: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.cpu_we;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_wmask = bus.cpu_we ?
                        bus.cpu_wmask : '0;
      end
      beat0: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.acc_we;
        bus.mem_addr  = bus.acc_addr;
        bus.mem_wdata = bus.acc_wdata;
        bus.mem_wmask = {MASK_W{1'b1}};
      end
      burst_beat: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = gen_addr;
        bus.mem_wdata = bus.acc_wdata;
        bus.mem_wmask = {MASK_W{1'b1}};
      end
      default: ;
    endcase
  end

  assign bus.cpu_valid  = (cpu_win && bus.cpu_we) || cpu_rd;
  assign bus.cpu_rdata  = (cpu_rd && own_q == OWN_CPU) ?
                          bus.mem_rdata : '0;
  assign bus.cpu_stall  = bus.cpu_req && !bus.cpu_valid &&
                          !reset;
  assign bus.acc_gnt    = acc_win;
  assign bus.acc_beat   = beat0 || burst_beat;
  assign bus.acc_rvalid = !reset && (own_q == OWN_ACC);
  assign bus.acc_rdata  = bus.acc_rvalid ?
                          bus.mem_rdata : '0;
  assign bus.acc_done   = !reset && done_q;

  a_burst_idx: assert property (
    @(posedge clk) disable iff (reset)
    (state_q == ACC_BURST) |-> (beat_idx != '0));
endmodule
